// File: rtl/trig_sched_pkg.sv
// Shared types for the trigger-chain scheduler: FSM states, capture order
// modes and the width of the inter-capture gap counter.
package trig_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      LSB = 2'b00,
      MSB = 2'b01,
      PAR = 2'b10
   } mode_t;

   localparam int GAP_CNT_W = 4;

   // Encoding 11 is folded onto parallel capture.
   function automatic mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'b00:   return LSB;
         2'b01:   return MSB;
         default: return PAR;
      endcase
   endfunction

endpackage

// File: rtl/trig_chain_sched_if.sv
// Bus bundle of the trigger-chain scheduler: input word handshake, capture
// enables and the downstream chain-image handshake.
// TRIG_SCHED_PARITY_EN adds the OPAR parity output.
interface trig_chain_sched_if #(
   parameter int N = 4
);

   logic         IVALID;
   logic         IREADY;
   logic [N-1:0] IDATA;
   logic [1:0]   MODE;
   logic [N-1:0] CLK_EN;
   logic [N-1:0] ODATA;
   logic         OVALID;
   logic         OREADY;
   logic         BUSY;
`ifdef TRIG_SCHED_PARITY_EN
   logic         OPAR;

   modport master (
      output IVALID, IDATA, MODE, OREADY,
      input  IREADY, CLK_EN, ODATA, OVALID, BUSY, OPAR
   );

   modport slave (
      input  IVALID, IDATA, MODE, OREADY,
      output IREADY, CLK_EN, ODATA, OVALID, BUSY, OPAR
   );
`else
   modport master (
      output IVALID, IDATA, MODE, OREADY,
      input  IREADY, CLK_EN, ODATA, OVALID, BUSY
   );

   modport slave (
      input  IVALID, IDATA, MODE, OREADY,
      output IREADY, CLK_EN, ODATA, OVALID, BUSY
   );
`endif

endinterface

// File: rtl/trig_gap_timer.sv
// Loadable down-counter timing the idle gap between two single-bit
// captures. done pulses during the last counted cycle, so a load of G
// keeps the caller waiting for exactly G enabled cycles.
module trig_gap_timer
   import trig_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [GAP_CNT_W-1:0] load_val,
   input  logic                 en,
   output logic                 done
);

   logic [GAP_CNT_W-1:0] cnt_q;

   // Count register: load wins, otherwise count down while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - GAP_CNT_W'(1);
      end
   end

   assign done = en && (cnt_q == GAP_CNT_W'(1));

endmodule

// File: rtl/trig_chain_sched.sv
// Trigger-chain capture scheduler. Accepts an N-bit word, then pulses one
// capture enable per chain flop in LSB-first, MSB-first or parallel order,
// with GAP idle cycles between serial captures, and finally offers the
// captured chain image downstream.
// CLK_EN is registered together with the state so the enable is high in
// the same cycle the FSM sits in SHIFT; the flop captures at the end of it.
// TRIG_SCHED_PARITY_EN adds OPAR, the registered XOR of the chain image.
module trig_chain_sched
   import trig_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int GAP = 0
) (
   input logic              CLK,
   input logic              RST,
   trig_chain_sched_if.slave bus
);

   localparam int                   IDX_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_VAL  = GAP_CNT_W'(GAP);

   state_t           state_q;
   state_t           state_nxt;
   mode_t            mode_q;
   mode_t            mode_in;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_nxt;
   logic [IDX_W-1:0] idx_step;
   logic [N-1:0]     hold_q;
   logic [N-1:0]     clk_en_q;
   logic [N-1:0]     clk_en_nxt;
   logic [N-1:0]     odata_q;
   logic [N-1:0]     odata_nxt;
   logic             accept;
   logic             last_bit;
   logic             gap_load;
   logic             gap_en;
   logic             gap_done;

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
      return N'(1) << i;
   endfunction

   assign mode_in   = decode_mode(bus.MODE);
   assign accept    = (state_q == IDLE) && bus.IVALID;
   assign last_bit  = (mode_q == MSB) ? (idx_q == '0) : (idx_q == LAST_IDX);
   assign idx_step  = (mode_q == MSB) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
   assign gap_en    = (state_q == WAIT);
   // Each chain flop loads its held bit only when its enable is high.
   assign odata_nxt = (odata_q & ~clk_en_q) | (hold_q & clk_en_q);

   trig_gap_timer u_gap (
      .clk      (CLK),
      .rst      (RST),
      .load     (gap_load),
      .load_val (GAP_VAL),
      .en       (gap_en),
      .done     (gap_done)
   );

   // Next state, next bit index and the enable pattern for the next cycle.
   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      clk_en_nxt = '0;
      gap_load   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_nxt  = SHIFT;
               idx_nxt    = (mode_in == MSB) ? LAST_IDX : '0;
               clk_en_nxt = (mode_in == PAR) ? '1 : onehot(idx_nxt);
            end
         end
         SHIFT: begin
            if ((mode_q == PAR) || last_bit) begin
               state_nxt = DONE;
            end else if (GAP == 0) begin
               idx_nxt    = idx_step;
               clk_en_nxt = onehot(idx_step);
            end else begin
               state_nxt = WAIT;
               gap_load  = 1'b1;
            end
         end
         WAIT: begin
            if (gap_done) begin
               state_nxt  = SHIFT;
               idx_nxt    = idx_step;
               clk_en_nxt = onehot(idx_step);
            end
         end
         DONE: begin
            if (bus.OREADY) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers and chain image; reset discards any partial capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         clk_en_q <= '0;
         odata_q  <= '0;
      end else begin
         state_q  <= state_nxt;
         idx_q    <= idx_nxt;
         clk_en_q <= clk_en_nxt;
         odata_q  <= odata_nxt;
      end
   end

   // Word and order are sampled only on the accepting handshake.
   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_q <= bus.IDATA;
         mode_q <= mode_in;
      end
   end

`ifdef TRIG_SCHED_PARITY_EN
   logic opar_q;

   // Parity follows the chain image one register stage later, like ODATA.
   always_ff @(posedge CLK) begin
      if (RST) begin
         opar_q <= 1'b0;
      end else begin
         opar_q <= ^odata_nxt;
      end
   end

   assign bus.OPAR = opar_q;
`endif

   assign bus.IREADY = (state_q == IDLE) && !RST;
   assign bus.CLK_EN = clk_en_q;
   assign bus.ODATA  = odata_q;
   assign bus.OVALID = (state_q == DONE);
   assign bus.BUSY   = (state_q == SHIFT) || (state_q == WAIT);

endmodule

// File: tb/tb_trig_chain_sched.sv
// Bench for trig_chain_sched: two instances (GAP=0 and GAP=2) share one
// randomized stimulus stream; every cycle each is compared with a model
// that derives the capture schedule from offsets since the accept.
module tb_trig_chain_sched;

   localparam int N    = 4;
   localparam int NG   = 2;
   localparam int GAP0 = 0;
   localparam int GAP1 = 2;

   logic         clk    = 1'b0;
   logic         rst    = 1'b1;
   logic         ivalid = 1'b0;
   logic         oready = 1'b0;
   logic [N-1:0] idata  = '0;
   logic [1:0]   mode   = 2'b00;

   int  n_chk  = 0;
   int  n_pass = 0;
   int  cyc    = 0;
   bit  chk_on = 1'b0;

   bit           m_act  [NG];
   int           m_off  [NG];
   logic [N-1:0] m_word [NG];
   logic [N-1:0] m_od   [NG];
   bit           m_par  [NG];
   bit           m_msb  [NG];

   always #5 clk = ~clk;

   trig_chain_sched_if #(.N(N)) if0 ();
   trig_chain_sched_if #(.N(N)) if1 ();

   assign if0.IVALID = ivalid;
   assign if0.IDATA  = idata;
   assign if0.MODE   = mode;
   assign if0.OREADY = oready;
   assign if1.IVALID = ivalid;
   assign if1.IDATA  = idata;
   assign if1.MODE   = mode;
   assign if1.OREADY = oready;

   trig_chain_sched #(.N(N), .GAP(GAP0)) dut0 (.CLK(clk), .RST(rst), .bus(if0));
   trig_chain_sched #(.N(N), .GAP(GAP1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));

   function automatic int gap_of(input int g);
      return (g == 0) ? GAP0 : GAP1;
   endfunction

   // Offset (from the accepting cycle) at which the word becomes valid.
   function automatic int done_off(input int g);
      return m_par[g] ? 2 : 2 + (N - 1) * (gap_of(g) + 1);
   endfunction

   // Serial bit k is captured at offset 1 + k*(GAP+1); parallel at offset 1.
   function automatic logic [N-1:0] exp_en(input int g);
      logic [N-1:0] v;
      int p;
      int k;
      v = '0;
      if (m_act[g]) begin
         if (m_par[g]) begin
            if (m_off[g] == 1) v = '1;
         end else begin
            p = m_off[g] - 1;
            if (p >= 0 && (p % (gap_of(g) + 1)) == 0) begin
               k = p / (gap_of(g) + 1);
               if (k < N) v[m_msb[g] ? (N - 1 - k) : k] = 1'b1;
            end
         end
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic chk_inst(input int g, input logic ir, input logic [N-1:0] en,
                           input logic [N-1:0] od, input logic ov, input logic bz,
                           input logic op);
      string t;
      bit    ov_e;
      t    = $sformatf("g%0d c%0d", gap_of(g), cyc);
      ov_e = m_act[g] && (m_off[g] >= done_off(g));
      chk({t, " iready"}, 32'(ir), 32'(!m_act[g] && !rst));
      chk({t, " clk_en"}, 32'(en), 32'(exp_en(g)));
      chk({t, " odata"},  32'(od), 32'(m_od[g]));
      chk({t, " ovalid"}, 32'(ov), 32'(ov_e));
      chk({t, " busy"},   32'(bz), 32'(m_act[g] && !ov_e));
`ifdef TRIG_SCHED_PARITY_EN
      chk({t, " opar"},   32'(op), 32'(^m_od[g]));
`else
      if (op !== 1'b0) chk({t, " opar_absent"}, 32'(op), 32'(0));
`endif
   endtask

   // Model update at a rising edge, from the inputs of the cycle just ended.
   task automatic mdl_edge(input int g);
      logic [N-1:0] en;
      en = exp_en(g);
      if (rst) begin
         m_act[g] = 1'b0;
         m_od[g]  = '0;
      end else begin
         m_od[g] = (m_od[g] & ~en) | (m_word[g] & en);
         if (!m_act[g]) begin
            if (ivalid) begin
               m_act[g]  = 1'b1;
               m_off[g]  = 1;
               m_word[g] = idata;
               m_par[g]  = mode[1];
               m_msb[g]  = (mode == 2'b01);
            end
         end else if (m_off[g] >= done_off(g) && oready) begin
            m_act[g] = 1'b0;
         end else begin
            m_off[g]++;
         end
      end
   endtask

   task automatic cycle(input logic iv, input logic [N-1:0] d, input logic [1:0] m,
                        input logic ordy, input logic r);
      ivalid = iv;
      idata  = d;
      mode   = m;
      oready = ordy;
      rst    = r;
      @(negedge clk);
      if (chk_on) begin
`ifdef TRIG_SCHED_PARITY_EN
         chk_inst(0, if0.IREADY, if0.CLK_EN, if0.ODATA, if0.OVALID, if0.BUSY, if0.OPAR);
         chk_inst(1, if1.IREADY, if1.CLK_EN, if1.ODATA, if1.OVALID, if1.BUSY, if1.OPAR);
`else
         chk_inst(0, if0.IREADY, if0.CLK_EN, if0.ODATA, if0.OVALID, if0.BUSY, 1'b0);
         chk_inst(1, if1.IREADY, if1.CLK_EN, if1.ODATA, if1.OVALID, if1.BUSY, 1'b0);
`endif
      end
      @(posedge clk);
      mdl_edge(0);
      mdl_edge(1);
      if (r) chk_on = 1'b1;
      cyc++;
      #1;
   endtask

   // One transfer with OREADY held low long enough for both gaps to finish.
   task automatic xfer(input logic [N-1:0] d, input logic [1:0] m);
      cycle(1'b1, d, m, 1'b0, 1'b0);
      repeat (14) cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);
      chk("word_g0",   32'(if0.ODATA),  32'(d));
      chk("word_g2",   32'(if1.ODATA),  32'(d));
      chk("ovalid_g0", 32'(if0.OVALID), 32'(1));
      chk("ovalid_g2", 32'(if1.OVALID), 32'(1));
`ifdef TRIG_SCHED_PARITY_EN
      chk("opar_g0",   32'(if0.OPAR),   32'(^d));
`endif
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);
      chk("iready_after_done", 32'(if0.IREADY), 32'(1));
   endtask

   initial begin
      for (int g = 0; g < NG; g++) begin
         m_act[g]  = 1'b0;
         m_off[g]  = 0;
         m_word[g] = '0;
         m_od[g]   = '0;
         m_par[g]  = 1'b0;
         m_msb[g]  = 1'b0;
      end
      @(posedge clk);
      #1;
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);

      xfer(4'b1011, 2'b00);
      xfer(4'b1011, 2'b01);
      xfer(4'b0110, 2'b00);
      xfer(4'b1100, 2'b10);
      xfer(4'b1100, 2'b11);

      // Reset in the middle of an LSB-first transfer.
      cycle(1'b1, 4'b1011, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
      chk("rst_odata", 32'(if1.ODATA),  32'(0));
      chk("rst_clken", 32'(if1.CLK_EN), 32'(0));
      chk("rst_busy",  32'(if1.BUSY),   32'(0));
      xfer(4'b0101, 2'b00);

      // Back-to-back: IVALID and OREADY held high.
      repeat (80) cycle(1'b1, N'($urandom), 2'($urandom), 1'b1, 1'b0);

      // Fully random traffic with occasional resets.
      repeat (1500) begin
         cycle(($urandom % 3) != 0, N'($urandom), 2'($urandom),
               ($urandom % 4) != 0, ($urandom % 97) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
